// File: rtl/hdmi_island_pkg.sv
// Shared types and timing constants for the HDMI data-island scheduler.
// Imported by data_island_scheduler and island_arbiter.
package hdmi_island_pkg;

   localparam int CTRL_LEAD     = 4;
   localparam int PREAMBLE      = 8;
   localparam int GUARD         = 2;
   localparam int VIDEO_TAIL    = 12;
   localparam int OVERHEAD      = CTRL_LEAD + PREAMBLE + 2 * GUARD + VIDEO_TAIL;
   localparam int PACKET_PIXELS = 32;

   typedef enum logic [1:0] {
      MODE_CTRL     = 2'd0,
      MODE_PREAMBLE = 2'd1,
      MODE_GUARD    = 2'd2,
      MODE_PACKET   = 2'd3
   } island_mode_t;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_CTRL_LEAD   = 3'd1,
      S_PREAMBLE    = 3'd2,
      S_GUARD_LEAD  = 3'd3,
      S_PACKET      = 3'd4,
      S_GUARD_TRAIL = 3'd5
   } island_state_t;

endpackage

// File: rtl/island_arbiter.sv
// Packet-slot arbiter: index 0 always wins; others are fixed priority, or
// round-robin when DATA_ISLAND_ROUND_ROBIN_EN is defined.
module island_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               enable_i,
   input  logic               clear_i,
   output logic [NUM_REQ-1:0] grant_o
);

   // Handshake: req_i is a level held by the source until it sees its bit in
   // grant_o; a grant is issued only in an enable_i slot, zero means null packet.
   logic [NUM_REQ-1:0] grant_d, grant_q;

`ifdef DATA_ISLAND_ROUND_ROBIN_EN
   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0] ptr_d, ptr_q;
   logic [PW-1:0] idx_s;
   int            idx;

   always_comb begin
      grant_d = '0;
      ptr_d   = ptr_q;
      idx     = 0;
      idx_s   = '0;
      if (clear_i) begin
         ptr_d = PW'(1);
      end
      if (enable_i) begin
         if (req_i[0]) begin
            grant_d[0] = 1'b1;
         end else begin
            // Pointer lives in 1..NUM_REQ-1; the search wraps within that range.
            for (int i = 0; i < NUM_REQ - 1; i++) begin
               idx = int'(ptr_q) + i;
               if (idx >= NUM_REQ) begin
                  idx = idx - (NUM_REQ - 1);
               end
               idx_s = PW'(idx);
               if (grant_d == '0 && req_i[idx_s]) begin
                  grant_d[idx_s] = 1'b1;
                  ptr_d = (idx == NUM_REQ - 1) ? PW'(1) : PW'(idx + 1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= PW'(1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_clear;
   assign unused_clear = clear_i;

   always_comb begin
      grant_d = '0;
      if (enable_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d == '0 && req_i[i]) begin
               grant_d[i] = 1'b1;
            end
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q <= '0;
      end else begin
         grant_q <= grant_d;
      end
   end

   assign grant_o = grant_q;

endmodule

// File: rtl/data_island_scheduler.sv
// Places one data island per horizontal blanking line and sequences its modes
// and packet slots. Optional round-robin arbitration: DATA_ISLAND_ROUND_ROBIN_EN.
module data_island_scheduler
   import hdmi_island_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int BLANK_WIDTH = 12,
   parameter int MAX_PACKETS = 18
) (
   input  logic                   clk_pixel,
   input  logic                   reset_n,
   input  logic                   hblank_start,
   input  logic [BLANK_WIDTH-1:0] hblank_length,
   input  logic                   video_field_end,
   input  logic [NUM_REQ-1:0]     req,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   packet_enable,
   output logic [4:0]             packet_pixel_counter,
   output logic [1:0]             mode,
   output logic [4:0]             island_packets,
   output logic                   overlap_err
);

   localparam int DW = BLANK_WIDTH + 1;
   localparam logic [DW-6:0] MAX_N = MAX_PACKETS[DW-6:0];

   island_state_t state_d, state_q;
   island_mode_t  mode_d, mode_q;
   logic [4:0]    cnt_d, cnt_q;
   logic [4:0]    pkt_d, pkt_q;
   logic [4:0]    npkt_d, npkt_q;
   logic [4:0]    ppc_d, ppc_q;
   logic          pe_d, pe_q;
   logic          ovl_d, ovl_q;
   logic [DW-1:0] excess;
   logic [DW-6:0] raw_n;
   logic [4:0]    n_calc;
   logic          accept;

   // Extra bit keeps short blanking intervals from wrapping to a huge count.
   always_comb begin
      excess = {1'b0, hblank_length} - DW'(OVERHEAD);
      raw_n  = excess[DW-1:5];
      n_calc = '0;
      if ({1'b0, hblank_length} >= DW'(OVERHEAD + PACKET_PIXELS)) begin
         n_calc = (raw_n > MAX_N) ? MAX_N[4:0] : raw_n[4:0];
      end
   end

   assign accept = hblank_start && (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pkt_d   = pkt_q;
      npkt_d  = accept ? n_calc : npkt_q;
      ovl_d   = ovl_q;
      if (video_field_end) begin
         ovl_d = 1'b0;
      end
      if (hblank_start && state_q != S_IDLE) begin
         ovl_d = 1'b1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (accept && n_calc != 5'd0) begin
               state_d = S_CTRL_LEAD;
               cnt_d   = '0;
            end
         end
         S_CTRL_LEAD: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(CTRL_LEAD - 1)) begin
               state_d = S_PREAMBLE;
               cnt_d   = '0;
            end
         end
         S_PREAMBLE: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(PREAMBLE - 1)) begin
               state_d = S_GUARD_LEAD;
               cnt_d   = '0;
            end
         end
         S_GUARD_LEAD: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(GUARD - 1)) begin
               state_d = S_PACKET;
               cnt_d   = '0;
               pkt_d   = '0;
            end
         end
         S_PACKET: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(PACKET_PIXELS - 1)) begin
               cnt_d = '0;
               if (pkt_q == npkt_q - 5'd1) begin
                  state_d = S_GUARD_TRAIL;
               end else begin
                  pkt_d = pkt_q + 5'd1;
               end
            end
         end
         S_GUARD_TRAIL: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(GUARD - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so each appears one edge after its pixel.
   always_comb begin
      mode_d = MODE_CTRL;
      ppc_d  = '0;
      pe_d   = 1'b0;
      unique case (state_d)
         S_PREAMBLE:                  mode_d = MODE_PREAMBLE;
         S_GUARD_LEAD, S_GUARD_TRAIL: mode_d = MODE_GUARD;
         S_PACKET:                    mode_d = MODE_PACKET;
         default:                     mode_d = MODE_CTRL;
      endcase
      if (state_d == S_PACKET) begin
         ppc_d = cnt_d;
      end
      if (state_d == S_GUARD_LEAD && cnt_d == 5'(GUARD - 1)) begin
         pe_d = 1'b1;
      end
      if (state_d == S_PACKET && cnt_d == 5'(PACKET_PIXELS - 1) && pkt_d != npkt_q - 5'd1) begin
         pe_d = 1'b1;
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pkt_q   <= '0;
         npkt_q  <= '0;
         mode_q  <= MODE_CTRL;
         ppc_q   <= '0;
         pe_q    <= 1'b0;
         ovl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pkt_q   <= pkt_d;
         npkt_q  <= npkt_d;
         mode_q  <= mode_d;
         ppc_q   <= ppc_d;
         pe_q    <= pe_d;
         ovl_q   <= ovl_d;
      end
   end

   island_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arbiter (
      .clk_i    (clk_pixel),
      .rst_ni   (reset_n),
      .req_i    (req),
      .enable_i (pe_d),
      .clear_i  (video_field_end),
      .grant_o  (grant)
   );

   assign mode                 = mode_q;
   assign packet_enable        = pe_q;
   assign packet_pixel_counter = ppc_q;
   assign island_packets       = npkt_q;
   assign overlap_err          = ovl_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler; expectations for grants follow
// whether DATA_ISLAND_ROUND_ROBIN_EN is defined for the build.
module tb_data_island_scheduler;

   logic        clk_pixel = 1'b0;
   logic        reset_n = 1'b0;
   logic        hblank_start = 1'b0;
   logic [11:0] hblank_length = '0;
   logic        video_field_end = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  grant;
   logic        packet_enable;
   logic [4:0]  packet_pixel_counter;
   logic [1:0]  mode;
   logic [4:0]  island_packets;
   logic        overlap_err;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];

   data_island_scheduler dut (
      .clk_pixel            (clk_pixel),
      .reset_n              (reset_n),
      .hblank_start         (hblank_start),
      .hblank_length        (hblank_length),
      .video_field_end      (video_field_end),
      .req                  (req),
      .grant                (grant),
      .packet_enable        (packet_enable),
      .packet_pixel_counter (packet_pixel_counter),
      .mode                 (mode),
      .island_packets       (island_packets),
      .overlap_err          (overlap_err)
   );

   always #5 clk_pixel = ~clk_pixel;

   function automatic int exp_mode(input int p, input int n);
      if (n == 0) return 0;
      if (p < 4) return 0;
      if (p < 12) return 1;
      if (p < 14) return 2;
      if (p < 14 + 32 * n) return 3;
      if (p < 16 + 32 * n) return 2;
      return 0;
   endfunction

   function automatic int exp_ppc(input int p, input int n);
      if (exp_mode(p, n) == 3) return (p - 14) % 32;
      return 0;
   endfunction

   function automatic int exp_pe(input int p, input int n);
      if (n == 0) return 0;
      if (p == 13) return 1;
      if (p >= 45 && (p - 45) % 32 == 0 && (p - 45) / 32 < n - 1) return 1;
      return 0;
   endfunction

   task automatic check(input string tag, input int p, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s p=%0d observed=%0h expected=%0h", tag, p, obs, expv);
      end
   endtask

   task automatic check_pixel(input int p, input int n);
      logic [3:0] g;
      g = 4'h0;
      check("mode", p, 32'(mode), 32'(exp_mode(p, n)));
      check("ppc", p, 32'(packet_pixel_counter), 32'(exp_ppc(p, n)));
      check("packet_enable", p, 32'(packet_enable), 32'(exp_pe(p, n)));
      if (exp_pe(p, n) != 0) begin
         g = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
      end
      check("grant", p, 32'(grant), 32'(g));
   endtask

   task automatic push_grants(input logic [3:0] g0, input logic [3:0] g1,
                              input logic [3:0] g2, input logic [3:0] g3);
      exp_q.push_back(g0);
      exp_q.push_back(g1);
      exp_q.push_back(g2);
      exp_q.push_back(g3);
   endtask

   // Drives one line starting at a negedge; ovl_p >= 0 re-pulses hblank_start mid-island.
   task automatic run_island(input int len, input int n, input int ovl_p);
      int last;
      last = (n == 0) ? 40 : 16 + 32 * n + 2;
      hblank_length = 12'(len);
      hblank_start  = 1'b1;
      @(negedge clk_pixel);
      check("island_packets_start", 0, 32'(island_packets), 32'(n));
      for (int p = 0; p <= last; p++) begin
         if (p == ovl_p) begin
            hblank_start  = 1'b1;
            hblank_length = 12'd60;
         end else begin
            hblank_start = 1'b0;
         end
         check_pixel(p, n);
         @(negedge clk_pixel);
      end
      hblank_start = 1'b0;
      check("island_packets_end", last, 32'(island_packets), 32'(n));
      check("slots_consumed", last, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      req = '0;
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_mode", 0, 32'(mode), 32'd0);
      check("rst_pe", 0, 32'(packet_enable), 32'd0);
      check("rst_grant", 0, 32'(grant), 32'd0);
      check("rst_ppc", 0, 32'(packet_pixel_counter), 32'd0);
      check("rst_ipk", 0, 32'(island_packets), 32'd0);
      check("rst_ovl", 0, 32'(overlap_err), 32'd0);
      repeat (3) @(negedge clk_pixel);
      reset_n = 1'b1;
      @(negedge clk_pixel);

      // L=160, no requests: four null-packet slots
      push_grants(4'h0, 4'h0, 4'h0, 4'h0);
      run_island(160, 4, -1);
      check("ovl_clean", 0, 32'(overlap_err), 32'd0);

      // Boundary around OVERHEAD+32
      run_island(59, 0, -1);
      exp_q.push_back(4'h0);
      run_island(60, 1, -1);

      // L=700 clips to 18 packets
      for (int k = 0; k < 18; k++) exp_q.push_back(4'h0);
      run_island(700, 18, -1);

      // Index 0 always wins
      req = 4'b1111;
      push_grants(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      run_island(160, 4, -1);

      // Sources 1..3 only
      req = 4'b1110;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
      push_grants(4'b0010, 4'b0100, 4'b1000, 4'b0010);
`else
      push_grants(4'b0010, 4'b0010, 4'b0010, 4'b0010);
`endif
      run_island(160, 4, -1);

      // Overlapping hblank_start: island completes unchanged, error sticks
      push_grants(4'h0, 4'h0, 4'h0, 4'h0);
      run_island(160, 4, 50);
      check("ovl_set", 0, 32'(overlap_err), 32'd1);
      repeat (5) @(negedge clk_pixel);
      check("ovl_sticky", 0, 32'(overlap_err), 32'd1);
      video_field_end = 1'b1;
      @(negedge clk_pixel);
      video_field_end = 1'b0;
      check("ovl_cleared", 0, 32'(overlap_err), 32'd0);

      // Reset mid-island at p=30
      push_grants(4'h0, 4'h0, 4'h0, 4'h0);
      hblank_length = 12'd160;
      hblank_start  = 1'b1;
      @(negedge clk_pixel);
      hblank_start = 1'b0;
      for (int p = 0; p < 30; p++) begin
         check_pixel(p, 4);
         @(negedge clk_pixel);
      end
      check("pre_rst_ppc", 30, 32'(packet_pixel_counter), 32'd16);
      reset_n = 1'b0;
      #1;
      check("async_mode", 30, 32'(mode), 32'd0);
      check("async_pe", 30, 32'(packet_enable), 32'd0);
      check("async_ppc", 30, 32'(packet_pixel_counter), 32'd0);
      check("async_ipk", 30, 32'(island_packets), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk_pixel);
      reset_n = 1'b1;
      for (int p = 0; p < 200; p++) begin
         @(negedge clk_pixel);
         check("quiet_mode", p, 32'(mode), 32'd0);
         check("quiet_pe", p, 32'(packet_enable), 32'd0);
         check("quiet_ppc", p, 32'(packet_pixel_counter), 32'd0);
      end

      // Fresh island after reset
      req = 4'b0100;
      exp_q.push_back(4'b0100);
      run_island(60, 1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_island_scheduler.md
# data_island_scheduler

Sequences HDMI data islands inside each horizontal blanking interval and shares the packet slots among several packet sources. It sits between the video timing generator and the packet selection and encoding logic. Per blanking line it decides whether an island fits and how many packets it holds, then emits period/mode, packet pixel counter and `packet_enable`. At every slot it grants one requester, or none, in which case a null packet is sent.

## Interface
Parameters:
- `NUM_REQ`, 4: number of packet requesters; index 0 is the highest-priority source (audio sample).
- `BLANK_WIDTH`, 12: width of `hblank_length`.
- `MAX_PACKETS`, 18: maximum packets per island.

Ports:
- `clk_pixel` in 1: pixel clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `hblank_start` in 1: one-cycle pulse on blanking pixel 0 of a line.
- `hblank_length` in BLANK_WIDTH: blanking pixels of this line; sampled with `hblank_start`.
- `video_field_end` in 1: one-cycle pulse at end of field.
- `req` in NUM_REQ: level requests, held until granted.
- `grant` out NUM_REQ: one-hot or zero, valid only with `packet_enable`.
- `packet_enable` out 1: one-cycle pulse, the cycle before each packet's first pixel.
- `packet_pixel_counter` out 5: pixel index 0..31 within the current packet, 0 outside packets.
- `mode` out 2: 0 control, 1 data-island preamble, 2 data-island guard band, 3 data-island packet.
- `island_packets` out 5: packet count of the current or most recent island.
- `overlap_err` out 1: sticky; set when `hblank_start` arrives while an island is in progress.

## Operation
- Constants: CTRL_LEAD=4, PREAMBLE=8, GUARD=2, VIDEO_TAIL=12, OVERHEAD=CTRL_LEAD+PREAMBLE+2*GUARD+VIDEO_TAIL=28.
- On `hblank_start`, with L=`hblank_length`:
  - N = (L-OVERHEAD)>>5, clipped to MAX_PACKETS.
  - If L<OVERHEAD+32, N=0 and no island is scheduled.
  - The subtraction is done at BLANK_WIDTH+1 bits so it does not underflow.
- FSM: IDLE -> CTRL_LEAD -> PREAMBLE -> GUARD_LEAD -> PACKET -> GUARD_TRAIL -> IDLE.
  - IDLE -> CTRL_LEAD on `hblank_start` with N>0; with N=0, stay in IDLE with `mode`=0.
  - CTRL_LEAD lasts 4 cycles, PREAMBLE 8, GUARD_LEAD 2.
  - PACKET lasts N*32 cycles; `packet_pixel_counter` wraps 31->0 between packets.
  - GUARD_TRAIL lasts 2 cycles, then IDLE.
- Blanking pixel timeline, with p=0 at `hblank_start`:
  - control: p=0..3
  - preamble: p=4..11
  - guard: p=12..13
  - packet k: p=14+32k .. 45+32k
  - trailing guard: two pixels after the last packet
- `packet_enable` fires at p=13 and at p=45+32k for k<N-1, i.e. exactly N pulses per island.
- Arbitration is evaluated on `req` in the `packet_enable` cycle:
  - `req[0]` always wins.
  - Otherwise the lowest asserted index wins.
  - With no request, `grant`=0 (null packet).
  - A requester drops `req` within 32 cycles of its grant.
- `hblank_start` while not in IDLE: ignored, sets `overlap_err`, and the island finishes unchanged.
- `video_field_end`: clears `overlap_err` and the round-robin pointer. It does not abort an island.

## Timing
- All outputs are registered. The output value for blanking pixel p appears at the rising edge p+1, so there is a fixed 1-cycle latency that the top level matches on the video path.
- Reset values:
  - `mode`=0, `packet_enable`=0, `grant`=0, `packet_pixel_counter`=0
  - `island_packets`=0, `overlap_err`=0
  - FSM in IDLE, round-robin pointer=1
- Reset mid-island: outputs return to the reset values asynchronously. The next island starts only on a fresh `hblank_start` after reset is released.
- `grant` updates in the same cycle as `packet_enable` and is 0 in every other cycle.
- `island_packets` loads N on an accepted `hblank_start` and holds until the next one.

## Configuration
- `DATA_ISLAND_ROUND_ROBIN_EN` defined:
  - Index 0 keeps absolute priority.
  - Indices 1..NUM_REQ-1 are served round-robin; the search starts at the pointer.
  - After granting index i≥1, the pointer moves to i+1, wrapping to 1.
- Not defined: fixed priority, lowest index wins, and no pointer register exists.

## Structure
- Shared package `hdmi_island_pkg`:
  - `island_mode_t` enum: CTRL=0, PREAMBLE=1, GUARD=2, PACKET=3.
  - Constants CTRL_LEAD, PREAMBLE, GUARD, VIDEO_TAIL, OVERHEAD, PACKET_PIXELS=32.
  - FSM state typedef.
- Sub-module `island_arbiter`: req/enable in, grant out, owning the round-robin pointer and the macro-dependent logic. The FSM and counters stay in `data_island_scheduler`.

## Test plan
- L=160, no req -> N=4, `island_packets`=4, four `packet_enable` pulses (p=13,45,77,109), `grant`=0 each time, `mode` sequence 0×4, 1×8, 2×2, 3×128, 2×2, then 0.
- L=59 -> no island, `mode` stays 0, `island_packets`=0. L=60 -> N=1, a single pulse at p=13.
- L=700 -> raw value 21 clipped to 18, 18 pulses, trailing guard at p=590..591.
- `req`=4'b1111 held on a 4-slot island:
  - with macro: grants 1,1,1,1 on every slot (index 0 always wins);
  - with `req`=4'b1110: grants 2,4,8,2 with the macro, 2,2,2,2 without.
- `hblank_start` re-pulsed at p=50 of an N=4 island -> island completes unchanged, `overlap_err`=1; `video_field_end` clears it.
- `reset_n` low at p=30 -> `mode`=0, `packet_enable`=0, `packet_pixel_counter`=0 asynchronously; no output activity until the next `hblank_start`.
